masked_adder_nbit: RTL and testbench

- Pipelined W-bit ripple-carry adder/subtractor over Boolean-masked operands with d shares.
- Built from masked XOR, register and HPC2 AND gadgets; glitch-robust probing-secure at order d-1.
- Generalises the masked 1-bit half adder to full W-bit add/sub with carry-in, carry-out, a valid pipeline and reset.
- Serves arithmetic in the masked decapsulation datapath; accepts one operation per cycle.

---
 rtl/masked_adder_nbit.sv | 254 +++++++++++++++++++++++++
 tb/tb_masked_adder_nbit.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/masked_adder_nbit.sv
// Masked W-bit ripple-carry adder/subtractor over d Boolean shares.
// Each bit position is one pipeline stage of two HPC2 AND gadgets
// (2-cycle latency each), so the whole operation takes 2*W cycles.
//
// Handshake: in_valid marks an operation on a/b/sub this cycle and is
// always accepted (no ready, no stall). out_valid rises exactly 2*W cycles
// later together with out_s/out_cout. Bubbles travel as out_valid=0.
//
// out_s/out_cout are forced to zero while out_valid is low. out_valid is a
// public signal, and all-zero shares are a valid masking of zero, so this
// reveals nothing. It keeps the outputs quiet after reset and during bubbles.

// HPC2 AND gadget: z = x & y over D shares.
// y and the randomness are registered in the first cycle. x is delayed one
// register so that it meets them in the second cycle. Each share i sums its
// own registered partial products.
module masked_hpc2_and #(
    parameter int D = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [D-1:0]           x_i,
    input  logic [D-1:0]           y_i,
    input  logic [D*(D-1)/2-1:0]   r_i,
    output logic [D-1:0]           z_o
);
    localparam int R  = D*(D-1)/2;
    localparam int NT = 2*D-1;

    // Position of r_ij (the pair {i,j}, unordered) inside r_i.
    function automatic int ridx(input int i, input int j);
        int lo;
        int hi;
        int base;
        lo   = (i < j) ? i : j;
        hi   = (i < j) ? j : i;
        base = 0;
        for (int k = 0; k < lo; k++) begin
            base += D - 1 - k;
        end
        return base + hi - lo - 1;
    endfunction

    // Dense slot for the j-th cross term of share i (j != i).
    function automatic int slot(input int i, input int j);
        return (j < i) ? j : j - 1;
    endfunction

    logic [D-1:0]  x_q;
    logic [D-1:0]  y_q;
    logic [R-1:0]  r_q;
    logic [D-2:0]  ymr_d  [D];
    logic [D-2:0]  ymr_q  [D];
    logic [NT-1:0] term_d [D];
    logic [NT-1:0] term_q [D];

    // First layer: blind each foreign share y_j with r_ij before it meets x_i.
    always_comb begin
        for (int i = 0; i < D; i++) begin
            ymr_d[i] = '0;
            for (int j = 0; j < D; j++) begin
                if (j != i) begin
                    ymr_d[i][slot(i, j)] = y_i[j] ^ r_i[ridx(i, j)];
                end
            end
        end
    end

    // First-layer registers: align x, y, r and the blinded cross shares.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
            r_q <= '0;
            for (int i = 0; i < D; i++) begin
                ymr_q[i] <= '0;
            end
        end else begin
            x_q <= x_i;
            y_q <= y_i;
            r_q <= r_i;
            for (int i = 0; i < D; i++) begin
                ymr_q[i] <= ymr_d[i];
            end
        end
    end

    // Second layer products:
    //   x_i&y_i,
    //   ~x_i&r_ij,
    //   x_i&(y_j^r_ij).
    always_comb begin
        for (int i = 0; i < D; i++) begin
            term_d[i]    = '0;
            term_d[i][0] = x_q[i] & y_q[i];
            for (int j = 0; j < D; j++) begin
                if (j != i) begin
                    term_d[i][1 + 2*slot(i, j)] = ~x_q[i] & r_q[ridx(i, j)];
                    term_d[i][2 + 2*slot(i, j)] = x_q[i] & ymr_q[i][slot(i, j)];
                end
            end
        end
    end

    // Second-layer registers: every product is registered before compression.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < D; i++) begin
                term_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < D; i++) begin
                term_q[i] <= term_d[i];
            end
        end
    end

    // Share-local compression of registered terms.
    always_comb begin
        for (int i = 0; i < D; i++) begin
            z_o[i] = ^term_q[i];
        end
    end
endmodule

module masked_adder_nbit #(
    parameter int W = 8,
    parameter int d = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    input  logic                         sub,
    input  logic [W*d-1:0]               a,
    input  logic [W*d-1:0]               b,
    input  logic [2*W*(d*(d-1)/2)-1:0]   rnd,
    output logic                         out_valid,
    output logic [W*d-1:0]               out_s,
    output logic [d-1:0]                 out_cout
);
    localparam int R   = d*(d-1)/2;
    localparam int LAT = 2*W;

    // Stage-boundary buses. Index i is the value seen by stage i.
    // Index W is the value leaving the last stage.
    logic [W:0][W*d-1:0] a_st;
    logic [W:0][W*d-1:0] b_st;
    logic [W:0][W*d-1:0] s_st;
    logic [W:0]          sub_st;
    logic [W:0][d-1:0]   c_st;
    logic [LAT-1:0]      vld_q;
    logic                unused_tail;

    assign a_st[0]   = a;
    assign b_st[0]   = b;
    assign sub_st[0] = sub;
    assign s_st[0]   = '0;
    // Carry-in is the public sub bit placed in share 0. It supplies the +1
    // of the two's complement.
    assign c_st[0]   = {{(d-1){1'b0}}, sub};

    for (genvar i = 0; i < W; i++) begin : g_stage
        logic [d-1:0]   a_bit;
        logic [d-1:0]   bp_bit;
        logic [d-1:0]   axb;
        logic [d-1:0]   g_sh;
        logic [d-1:0]   t_sh;
        logic [W*d-1:0] s_ins;
        logic [W*d-1:0] a1_q, a2_q;
        logic [W*d-1:0] b1_q, b2_q;
        logic [W*d-1:0] s1_q, s2_q;
        logic           sub1_q, sub2_q;

        // b'_i: the public sub bit inverts share 0 only. The inversion uses
        // the sub copy that travels with this operation.
        assign a_bit  = a_st[i][i*d +: d];
        assign bp_bit = b_st[i][i*d +: d] ^ {{(d-1){1'b0}}, sub_st[i]};
        assign axb    = a_bit ^ bp_bit;

        // Sum bit of this stage inserted into the travelling result vector.
        always_comb begin
            s_ins             = s_st[i];
            s_ins[i*d +: d]   = axb ^ c_st[i];
        end

        // Generate term: g_i = a_i & b'_i.
        masked_hpc2_and #(.D(d)) u_gen (
            .clk   (clk),
            .rst_n (rst_n),
            .x_i   (a_bit),
            .y_i   (bp_bit),
            .r_i   (rnd[2*i*R +: R]),
            .z_o   (g_sh)
        );

        // Propagate term: t_i = c_i & (a_i ^ b'_i).
        masked_hpc2_and #(.D(d)) u_prop (
            .clk   (clk),
            .rst_n (rst_n),
            .x_i   (c_st[i]),
            .y_i   (axb),
            .r_i   (rnd[2*i*R + R +: R]),
            .z_o   (t_sh)
        );

        // Two-deep share registers keep operands, sub and the partial sum
        // aligned with the gadget latency.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                a1_q   <= '0;
                a2_q   <= '0;
                b1_q   <= '0;
                b2_q   <= '0;
                s1_q   <= '0;
                s2_q   <= '0;
                sub1_q <= 1'b0;
                sub2_q <= 1'b0;
            end else begin
                a1_q   <= a_st[i];
                a2_q   <= a1_q;
                b1_q   <= b_st[i];
                b2_q   <= b1_q;
                s1_q   <= s_ins;
                s2_q   <= s1_q;
                sub1_q <= sub_st[i];
                sub2_q <= sub1_q;
            end
        end

        assign a_st[i+1]   = a2_q;
        assign b_st[i+1]   = b2_q;
        assign s_st[i+1]   = s2_q;
        assign sub_st[i+1] = sub2_q;
        // The carry shares recombine only with their own share index.
        assign c_st[i+1]   = g_sh ^ t_sh;
    end

    // Valid shift register, LAT deep. It is cleared by reset, so in-flight
    // operations are discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else begin
            vld_q <= {vld_q[LAT-2:0], in_valid};
        end
    end

    assign out_valid = vld_q[LAT-1];
    assign out_s     = out_valid ? s_st[W] : '0;
    assign out_cout  = out_valid ? c_st[W] : '0;

    // Operand and sub copies past the last stage have no consumer.
    assign unused_tail = ^{a_st[W], b_st[W], sub_st[W]};
endmodule

// File: tb/tb_masked_adder_nbit.sv
// Bench for masked_adder_nbit.
// It drives a main instance (W=8, d=2) and two side instances (W=1, d=2 and
// W=8, d=3). Expected results come from plain modular arithmetic on the
// unmasked operands.
module tb_masked_adder_nbit;
    localparam int W   = 8;
    localparam int D   = 2;
    localparam int LAT = 2*W;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    // Main instance
    logic              in_valid, sub;
    logic [W*D-1:0]    a, b;
    logic [2*W-1:0]    rnd;
    logic              out_valid;
    logic [W*D-1:0]    out_s;
    logic [D-1:0]      out_cout;

    // W=1 instance
    logic        v1_in, sub1, v1_out;
    logic [1:0]  a1, b1, rnd1, s1, c1;

    // d=3 instance
    logic        v3_in, sub3, v3_out;
    logic [23:0] a3, b3, s3;
    logic [47:0] rnd3;
    logic [2:0]  c3;

    int errors = 0;
    int checks = 0;
    bit rnd_zero = 1'b0;
    // Queue entries are {valid, cout, sum}, one per cycle.
    logic [W+1:0] exp_q[$];
    logic [W*D-1:0] raw1, raw2;

    masked_adder_nbit #(.W(W), .d(D)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .sub(sub),
        .a(a), .b(b), .rnd(rnd),
        .out_valid(out_valid), .out_s(out_s), .out_cout(out_cout)
    );

    masked_adder_nbit #(.W(1), .d(2)) dut_w1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1_in), .sub(sub1),
        .a(a1), .b(b1), .rnd(rnd1),
        .out_valid(v1_out), .out_s(s1), .out_cout(c1)
    );

    masked_adder_nbit #(.W(8), .d(3)) dut_d3 (
        .clk(clk), .rst_n(rst_n), .in_valid(v3_in), .sub(sub3),
        .a(a3), .b(b3), .rnd(rnd3),
        .out_valid(v3_out), .out_s(s3), .out_cout(c3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Golden arithmetic on unmasked values.
    task automatic model(input int w, input int av, input int bv, input bit sb,
                         output logic [31:0] s, output logic c);
        longint m;
        m = longint'(1) << w;
        if (sb) begin
            s = 32'((longint'(av) - longint'(bv) + m) % m);
            c = (av >= bv);
        end else begin
            s = 32'((longint'(av) + longint'(bv)) % m);
            c = ((longint'(av) + longint'(bv)) >= m);
        end
    endtask

    // Split each bit of val into dd shares. mode 0: random extra shares,
    // 1: extra shares 0, 2: extra shares 1.
    function automatic logic [31:0] mask_val(input int w, input int dd, input int val, input int mode);
        logic [31:0] v;
        logic        s0, r;
        v = '0;
        for (int i = 0; i < w; i++) begin
            s0 = val[i];
            for (int k = 1; k < dd; k++) begin
                r = (mode == 0) ? 1'($urandom_range(0, 1)) : (mode == 2);
                v[i*dd + k] = r;
                s0 ^= r;
            end
            v[i*dd] = s0;
        end
        return v;
    endfunction

    function automatic logic [31:0] unmask(input int w, input int dd, input logic [31:0] v);
        logic [31:0] res;
        logic        x;
        res = '0;
        for (int i = 0; i < w; i++) begin
            x = 1'b0;
            for (int k = 0; k < dd; k++) begin
                x ^= v[i*dd + k];
            end
            res[i] = x;
        end
        return res;
    endfunction

    // Apply one main-instance input for the coming edge and queue its result.
    task automatic drive(input bit v, input int av, input int bv, input bit sb, input int mode);
        logic [31:0] ma, mb, es;
        logic        ec;
        ma = mask_val(W, D, av, mode);
        mb = mask_val(W, D, bv, (mode == 2) ? 1 : mode);
        in_valid = v;
        sub      = sb;
        a        = ma[W*D-1:0];
        b        = mb[W*D-1:0];
        rnd      = rnd_zero ? '0 : 16'($urandom);
        model(W, av, bv, sb, es, ec);
        exp_q.push_back({v, ec, es[W-1:0]});
    endtask

    // One clock. Check the main instance against the entry queued LAT cycles ago.
    task automatic tick();
        logic [W+1:0] e;
        rnd1 = 2'($urandom);
        rnd3 = {16'($urandom), $urandom};
        @(posedge clk);
        #1;
        if (exp_q.size() == LAT) begin
            e = exp_q.pop_front();
            check("valid", out_valid, e[W+1]);
            if (e[W+1]) begin
                check("sum", unmask(W, D, out_s), e[W-1:0]);
                check("cout", unmask(1, D, out_cout), e[W]);
            end
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        v1_in    = 1'b0;
        v3_in    = 1'b0;
        #2;
        check("rst_valid", out_valid, 0);
        check("rst_s", out_s, 0);
        check("rst_cout", out_cout, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        repeat (LAT-1) exp_q.push_back('0);
    endtask

    // Run the same operation through the W=1 and d=3 instances.
    task automatic corner_other(input int av, input int bv, input bit sb);
        logic [31:0] m, es;
        logic        ec;
        m = mask_val(1, 2, av & 1, 0);  a1 = m[1:0];
        m = mask_val(1, 2, bv & 1, 0);  b1 = m[1:0];
        m = mask_val(8, 3, av, 0);      a3 = m[23:0];
        m = mask_val(8, 3, bv, 0);      b3 = m[23:0];
        sub1 = sb;  sub3 = sb;
        v1_in = 1'b1;  v3_in = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            drive(0, 0, 0, 0, 0);
            tick();
            v1_in = 1'b0;
            v3_in = 1'b0;
            if (n == 1) check("w1_early", v1_out, 0);
            if (n == 2) begin
                model(1, av & 1, bv & 1, sb, es, ec);
                check("w1_valid", v1_out, 1);
                check("w1_sum", unmask(1, 2, 32'(s1)), es);
                check("w1_cout", unmask(1, 2, 32'(c1)), 32'(ec));
            end
            if (n == 15) check("d3_early", v3_out, 0);
            if (n == 16) begin
                model(8, av, bv, sb, es, ec);
                check("d3_valid", v3_out, 1);
                check("d3_sum", unmask(8, 3, 32'(s3)), es);
                check("d3_cout", unmask(1, 3, 32'(c3)), 32'(ec));
            end
        end
    endtask

    initial begin
        in_valid = 0; sub = 0; a = '0; b = '0; rnd = '0;
        v1_in = 0; sub1 = 0; a1 = '0; b1 = '0; rnd1 = '0;
        v3_in = 0; sub3 = 0; a3 = '0; b3 = '0; rnd3 = '0;
        #1;
        do_reset();

        // Single pulse: 200+100 -> 44, cout 1, valid only at +16
        drive(1, 200, 100, 0, 0);
        tick();
        repeat (20) begin drive(0, 0, 0, 0, 0); tick(); end

        // Directed subtractions and corners, back to back
        drive(1, 5, 7, 1, 0);     tick();
        drive(1, 7, 5, 1, 0);     tick();
        drive(1, 255, 255, 0, 0); tick();
        drive(1, 0, 0, 1, 0);     tick();
        drive(1, 0, 1, 1, 0);     tick();
        repeat (LAT) begin drive(0, 0, 0, 0, 0); tick(); end

        // The same corners on W=1 and d=3
        corner_other(255, 255, 0);
        corner_other(0, 0, 1);
        corner_other(0, 1, 1);

        // Random stream with bubbles
        for (int k = 0; k < 1000; k++) begin
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 255),
                  $urandom_range(0, 255), 1'($urandom_range(0, 1)), 0);
            tick();
        end
        repeat (LAT) begin drive(0, 0, 0, 0, 0); tick(); end

        // Reset with five operations in flight, then one fresh operation
        for (int k = 0; k < 5; k++) begin
            drive(1, $urandom_range(0, 255), $urandom_range(0, 255), 1'($urandom_range(0, 1)), 0);
            tick();
        end
        do_reset();
        drive(1, 123, 45, 1, 0);
        tick();
        repeat (LAT + 4) begin drive(0, 0, 0, 0, 0); tick(); end

        // Same operands, different masks and randomness
        rnd_zero = 1'b1;
        drive(1, 77, 150, 0, 1);
        tick();
        repeat (LAT-1) begin drive(0, 0, 0, 0, 1); tick(); end
        raw1 = out_s;
        rnd_zero = 1'b0;
        drive(1, 77, 150, 0, 2);
        tick();
        repeat (LAT-1) begin drive(0, 0, 0, 0, 0); tick(); end
        raw2 = out_s;
        checks++;
        assert (raw1 !== raw2) else begin
            errors++;
            $error("FAIL share_diff: observed %0h expected differing from %0h", raw2, raw1);
        end
        repeat (4) begin drive(0, 0, 0, 0, 0); tick(); end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
